// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - two-requester arbiter in front of the shared SPI driver, with busy watchdog
// Define SPI_ARB_ROUND_ROBIN_EN for alternating grants on contention instead of sweep priority.
module spi_bus_arbiter #(
    parameter int DATA_W     = 40,
    parameter int TIMEOUT    = 1023,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sweep_req,
    input  logic [DATA_W-1:0] sweep_data,
    output logic              sweep_ack,
    input  logic              cfg_req,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ack,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    output logic              spi_sel,
    input  logic              spi_busy,
    output logic              arb_busy,
    output logic              timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                sel_q, sel_d;
    logic                start_q, start_d;
    logic                sack_q, sack_d;
    logic                cack_q, cack_d;
    logic                err_q, err_d;
    logic                abusy_q, abusy_d;
    logic                pref_cfg, grant_s, grant_c;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic                last_sweep_q, last_sweep_d;
    assign pref_cfg = last_sweep_q;
`else
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0]     starve_q, starve_d;
    assign pref_cfg = (starve_q == SC_W'(STARVE_MAX));
`endif

    assign grant_s = sweep_req && (!cfg_req || !pref_cfg);
    assign grant_c = cfg_req && !grant_s;

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = err_q;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        last_sweep_d = last_sweep_q;
`else
        starve_d = starve_q;
`endif
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (grant_s || grant_c) begin
                    data_d  = grant_c ? cfg_data : sweep_data;
                    sel_d   = grant_c;
                    state_d = ISSUE;
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    last_sweep_d = grant_s;
`endif
                end
`ifndef SPI_ARB_ROUND_ROBIN_EN
                if (!cfg_req || grant_c) begin
                    starve_d = '0;
                end else if (grant_s && !pref_cfg) begin
                    starve_d = starve_q + SC_W'(1);
                end
`endif
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = ACCEPT;
            end
            ACCEPT: begin
                if (wdog_q == WD_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (spi_busy) begin
                    wdog_d  = '0;
                    state_d = XFER;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            XFER: begin
                if (wdog_q == WD_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!spi_busy) begin
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes are registered: start trails ISSUE by one cycle, acks coincide with DONE.
        start_d = (state_q == ISSUE);
        sack_d  = (state_d == DONE) && !sel_q;
        cack_d  = (state_d == DONE) && sel_q;
        abusy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wdog_q  <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            start_q <= 1'b0;
            sack_q  <= 1'b0;
            cack_q  <= 1'b0;
            err_q   <= 1'b0;
            abusy_q <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_sweep_q <= 1'b0;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            sack_q  <= sack_d;
            cack_q  <= cack_d;
            err_q   <= err_d;
            abusy_q <= abusy_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_sweep_q <= last_sweep_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    assign sweep_ack   = sack_q;
    assign cfg_ack     = cack_q;
    assign spi_start   = start_q;
    assign spi_data    = data_q;
    assign spi_sel     = sel_q;
    assign arb_busy    = abusy_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - directed and randomized checks of spi_bus_arbiter against a grant/timing model
module tb_spi_bus_arbiter;
    localparam int DATA_W     = 40;
    localparam int TIMEOUT    = 1023;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic              sweep_req;
    logic [DATA_W-1:0] sweep_data;
    logic              sweep_ack;
    logic              cfg_req;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_ack;
    logic              spi_start;
    logic [DATA_W-1:0] spi_data;
    logic              spi_sel;
    logic              spi_busy;
    logic              arb_busy;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: consecutive sweep wins under contention, last winner, sticky error.
    int m_starve     = 0;
    bit m_last_sweep = 1'b0;
    bit m_err        = 1'b0;

    spi_bus_arbiter #(
        .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sweep_req(sweep_req), .sweep_data(sweep_data), .sweep_ack(sweep_ack),
        .cfg_req(cfg_req), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
        .spi_start(spi_start), .spi_data(spi_data), .spi_sel(spi_sel),
        .spi_busy(spi_busy), .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit predict_cfg(input bit s, input bit c);
`ifdef SPI_ARB_ROUND_ROBIN_EN
        return c && (!s || m_last_sweep);
`else
        return c && (!s || m_starve == STARVE_MAX);
`endif
    endfunction

    task automatic model_grant(input bit s, input bit c, input bit w_cfg);
        if (s || c) m_last_sweep = !w_cfg;
        if (!c || w_cfg) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
    endtask

    function automatic logic [DATA_W-1:0] rand_frame();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after ack.
    // L = busy length (0 = driver never answers); mode 0 drop req after ack, 1 keep, 2 drop in XFER.
    task automatic run_xfer(input bit s, input bit c, input logic [DATA_W-1:0] sd,
                            input logic [DATA_W-1:0] cd, input int L, input int mode,
                            output bit w_cfg);
        int ack_cyc;
        logic [DATA_W-1:0] exp_d;
        w_cfg = predict_cfg(s, c);
        exp_d = w_cfg ? cd : sd;
        sweep_req = s; cfg_req = c; sweep_data = sd; cfg_data = cd;
        @(negedge clk);
        chk("idle_arb_busy", arb_busy, 0);
        chk("idle_no_ack", {sweep_ack, cfg_ack}, 0);
        model_grant(s, c, w_cfg);
        @(posedge clk); #1; @(negedge clk);
        chk("issue_arb_busy", arb_busy, 1);
        chk("issue_no_start", spi_start, 0);
        chk("grant_sel", spi_sel, w_cfg);
        chk("grant_data", spi_data, exp_d);
        @(posedge clk); #1; @(negedge clk);
        chk("start_latency", spi_start, 1);
        ack_cyc = -1;
        for (int cyc = 3; cyc < TIMEOUT + 12; cyc++) begin
            @(posedge clk); #1;
            spi_busy = (L > 0) && (cyc < 3 + L);
            if (mode == 2 && cyc == 4) begin sweep_req = 1'b0; cfg_req = 1'b0; end
            @(negedge clk);
            if (cyc == 3) chk("start_one_cycle", spi_start, 0);
            if (sweep_ack || cfg_ack) begin ack_cyc = cyc; break; end
        end
        if (L > 0) begin
            chk("ack_latency", ack_cyc, 4 + L);
        end else begin
            m_err = 1'b1;
            chk("timeout_window", (ack_cyc == 2 + TIMEOUT) || (ack_cyc == 3 + TIMEOUT), 1);
        end
        chk("sweep_ack", sweep_ack, !w_cfg);
        chk("cfg_ack", cfg_ack, w_cfg);
        chk("timeout_err", timeout_err, m_err);
        chk("data_held", spi_data, exp_d);
        @(posedge clk); #1;
        spi_busy = 1'b0;
        if (mode == 0) begin sweep_req = 1'b0; cfg_req = 1'b0; end
    endtask

    task automatic idle_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk("stay_idle", {arb_busy, spi_start, sweep_ack, cfg_ack}, 0);
            if (!cfg_req) m_starve = 0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit w;
        logic [DATA_W-1:0] cd;
        rst_n = 1'b0; sweep_req = 1'b0; cfg_req = 1'b0; spi_busy = 1'b0;
        sweep_data = '0; cfg_data = '0;
        #2;
        chk("reset_outputs", {spi_start, spi_sel, arb_busy, sweep_ack, cfg_ack, timeout_err, spi_data}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle_ticks(2);

        // Single sweep transfer with a known frame.
        run_xfer(1'b1, 1'b0, 40'h02_1234_5678, rand_frame(), 5, 0, w);
        chk("t1_winner", w, 0);
        idle_ticks(2);

        // Sustained contention: grant order from the model and from the fixed pattern.
        for (int i = 0; i < 12; i++) begin
            run_xfer(1'b1, 1'b1, rand_frame(), rand_frame(), $urandom_range(1, 4), (i == 11) ? 0 : 1, w);
`ifndef SPI_ARB_ROUND_ROBIN_EN
            chk("contention_order", w, (i % 5) == 4);
`endif
        end
        idle_ticks(2);

        // cfg drops its request mid-transfer: one ack, no re-grant.
        run_xfer(1'b0, 1'b1, rand_frame(), rand_frame(), 4, 2, w);
        idle_ticks(3);

        // Request held one cycle past ack: exactly one extra grant.
        run_xfer(1'b0, 1'b1, rand_frame(), rand_frame(), 3, 1, w);
        run_xfer(1'b0, 1'b1, rand_frame(), rand_frame(), 3, 2, w);
        idle_ticks(3);

        // Driver never raises busy: watchdog abort, then normal service.
        run_xfer(1'b1, 1'b0, rand_frame(), rand_frame(), 0, 0, w);
        idle_ticks(1);
        run_xfer(1'b1, 1'b0, rand_frame(), rand_frame(), 3, 0, w);
        idle_ticks(1);

        // Asynchronous reset during XFER with cfg_req pending.
        cd = rand_frame();
        cfg_req = 1'b1; cfg_data = cd; sweep_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        spi_busy = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_in_xfer", arb_busy, 1);
        rst_n = 1'b0; #1;
        chk("reset_mid_outputs", {spi_start, spi_sel, arb_busy, sweep_ack, cfg_ack, timeout_err, spi_data}, 0);
        spi_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_in_reset", {sweep_ack, cfg_ack}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_starve = 0; m_last_sweep = 1'b0; m_err = 1'b0;
        run_xfer(1'b0, 1'b1, rand_frame(), cd, 2, 0, w);
        chk("post_reset_cfg_grant", w, 1);
        idle_ticks(1);

        // Randomized request mix against the model.
        for (int i = 0; i < 24; i++) begin
            bit s, c;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            if (!s && !c) begin
                idle_ticks(2);
            end else begin
                run_xfer(s, c, rand_frame(), rand_frame(), $urandom_range(1, 6),
                         ($urandom_range(0, 1) == 1) ? 2 : 0, w);
            end
        end
        idle_ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
